// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: per-register control codes,
// fetch redirect types and the interrupt sequencing FSM states.
package pipe_ctrl_pkg;

    localparam logic [1:0] CTR_ADV  = 2'b00;
    localparam logic [1:0] CTR_BUB  = 2'b01;
    localparam logic [1:0] CTR_HOLD = 2'b10;

    localparam logic [1:0] JT_NONE = 2'b00;
    localparam logic [1:0] JT_JMPR = 2'b01;
    localparam logic [1:0] JT_JMPI = 2'b10;
    localparam logic [1:0] JT_INT  = 2'b11;

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        DRAIN    = 2'b01,
        REDIRECT = 2'b10
    } state_t;

    // Taken-jump redirect type from the target-kind bit.
    function automatic logic [1:0] jump_type(input logic imm_target);
        return imm_target ? JT_JMPI : JT_JMPR;
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_load_use_cmp.sv
// Load-use detector: flags a hazard when any read operand of the ID instruction
// names the destination of the load currently in EX.
module load_use_cmp #(
    parameter int REG_W       = 4,
    parameter int NSRC        = 2,
    parameter int ZERO_EXEMPT = 0
) (
    input  logic                    is_load_i,
    input  logic [NSRC-1:0]         src_use_i,
    input  logic [NSRC*REG_W-1:0]   src_id_i,
    input  logic [REG_W-1:0]        dst_ex_i,
    output logic                    hazard_o
);

    logic [NSRC-1:0] match_s;
    logic            exempt_s;

    // Per-operand index comparators.
    always_comb begin
        match_s = {NSRC{1'b0}};
        for (int i = 0; i < NSRC; i++) begin
            match_s[i] = src_use_i[i] && (src_id_i[i*REG_W +: REG_W] == dst_ex_i);
        end
    end

    // A match implies src == dst, so masking on dst == 0 exempts register 0 on both sides.
    assign exempt_s = (ZERO_EXEMPT != 0) && (dst_ex_i == {REG_W{1'b0}});
    assign hazard_o = is_load_i && !exempt_s && (|match_s);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/redirect controller: per-register advance/bubble/hold, jump redirects,
// latched prioritised interrupts with a drain/redirect sequence, and a stall watchdog.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int NSTAGE      = 4,
    parameter int REG_W       = 4,
    parameter int NSRC        = 2,
    parameter int NINT        = 3,
    parameter int CNT_W       = 4,
    parameter int ZERO_EXEMPT = 0
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    pval,
    input  logic [NSTAGE-1:0]                       busy,
    input  logic [1:0]                              jmp,
    input  logic [NINT-1:0]                         intp,
    input  logic                                    int_en,
    input  logic                                    is_load,
    input  logic [NSRC-1:0]                         src_use,
    input  logic [NSRC*REG_W-1:0]                   src_id,
    input  logic [REG_W-1:0]                        dst_ex,
    output logic [2*NSTAGE-1:0]                     stage_ctr,
    output logic [1:0]                              jmp_type,
    output logic [((NINT > 1) ? $clog2(NINT) : 1)-1:0] int_cause,
    output logic                                    int_ack,
    output logic [CNT_W-1:0]                        stall_cnt,
    output logic                                    hang
);

    localparam int CW = (NINT > 1) ? $clog2(NINT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t              state_q, state_d;
    logic [NINT-1:0]     pend_q, pend_d, pend_clr_s;
    logic [CW-1:0]       cause_q, cause_d, pend_low_s;
    logic [2*NSTAGE-1:0] ctr_q, ctr_d;
    logic [1:0]          jt_q, jt_d;
    logic                ack_q, ack_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                hang_q, hang_d;
    logic                lu_haz_s;
    logic                busy_any_s;
    logic                any_hold_s;
    int                  busy_top_s;

    load_use_cmp #(
        .REG_W       (REG_W),
        .NSRC        (NSRC),
        .ZERO_EXEMPT (ZERO_EXEMPT)
    ) u_load_use_cmp (
        .is_load_i (is_load),
        .src_use_i (src_use),
        .src_id_i  (src_id),
        .dst_ex_i  (dst_ex),
        .hazard_o  (lu_haz_s)
    );

    assign busy_any_s = |busy;

    // Highest busy register and lowest (highest-priority) pending cause.
    always_comb begin
        busy_top_s = 0;
        pend_low_s = {CW{1'b0}};
        for (int k = 0; k < NSTAGE; k++) begin
            if (busy[k]) begin
                busy_top_s = k;
            end else begin
                busy_top_s = busy_top_s;
            end
        end
        for (int i = NINT - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                pend_low_s = CW'(i);
            end else begin
                pend_low_s = pend_low_s;
            end
        end
    end

    // FSM next state and next registered controls.
    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        ctr_d   = {(2*NSTAGE){1'b0}};
        jt_d    = JT_NONE;
        ack_d   = 1'b0;
        case (state_q)
            RUN: begin
                if (|pend_q) begin
                    state_d = DRAIN;
                    cause_d = pend_low_s;
                    if (busy_any_s) begin
                        ctr_d = {NSTAGE{CTR_HOLD}};
                    end else begin
                        ctr_d = {NSTAGE{CTR_ADV}};
                    end
                end else if (busy_any_s) begin
                    for (int k = 0; k < NSTAGE; k++) begin
                        if (k <= busy_top_s) begin
                            ctr_d[2*k +: 2] = CTR_HOLD;
                        end else if (k == busy_top_s + 1) begin
                            ctr_d[2*k +: 2] = CTR_BUB;
                        end else begin
                            ctr_d[2*k +: 2] = CTR_ADV;
                        end
                    end
                end else if (!pval) begin
                    ctr_d[3:2] = CTR_BUB;
                end else if (lu_haz_s) begin
                    // The jump is dropped here; ID re-presents it once the load resolves.
                    ctr_d[1:0] = CTR_HOLD;
                    ctr_d[3:2] = CTR_BUB;
                end else if (jmp[0]) begin
                    ctr_d[1:0] = CTR_BUB;
                    jt_d       = jump_type(jmp[1]);
                end else begin
                    ctr_d = {NSTAGE{CTR_ADV}};
                end
            end
            DRAIN: begin
                if (busy_any_s) begin
                    ctr_d = {NSTAGE{CTR_HOLD}};
                end else begin
                    state_d = REDIRECT;
                end
            end
            REDIRECT: begin
                ctr_d   = {NSTAGE{CTR_BUB}};
                jt_d    = JT_INT;
                ack_d   = 1'b1;
                state_d = RUN;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // Pending causes: new samples win over a same-cycle acknowledge.
    always_comb begin
        pend_clr_s = {NINT{1'b0}};
        for (int i = 0; i < NINT; i++) begin
            pend_clr_s[i] = (state_q == REDIRECT) && (cause_q == CW'(i));
        end
        pend_d = (pend_q & ~pend_clr_s) | (intp & {NINT{int_en}});
    end

    // Watchdog follows the controls being registered this edge.
    always_comb begin
        any_hold_s = 1'b0;
        for (int k = 0; k < NSTAGE; k++) begin
            if (ctr_d[2*k +: 2] == CTR_HOLD) begin
                any_hold_s = 1'b1;
            end else begin
                any_hold_s = any_hold_s;
            end
        end
        if (!any_hold_s) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = CNT_MAX;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        hang_d = (cnt_d == CNT_MAX);
    end

    // State and output registers, updated on the falling clock edge.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            pend_q  <= {NINT{1'b0}};
            cause_q <= {CW{1'b0}};
            ctr_q   <= {(2*NSTAGE){1'b0}};
            jt_q    <= JT_NONE;
            ack_q   <= 1'b0;
            cnt_q   <= {CNT_W{1'b0}};
            hang_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            cause_q <= cause_d;
            ctr_q   <= ctr_d;
            jt_q    <= jt_d;
            ack_q   <= ack_d;
            cnt_q   <= cnt_d;
            hang_q  <= hang_d;
        end
    end

    assign stage_ctr = ctr_q;
    assign jmp_type  = jt_q;
    assign int_cause = cause_q;
    assign int_ack   = ack_q;
    assign stall_cnt = cnt_q;
    assign hang      = hang_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: table-driven single-cycle priority vectors plus
// hand sequences for interrupts, reset mid-drain and the stall watchdog.
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pval = 1'b1;
    logic [3:0] busy = 4'b0000;
    logic [1:0] jmp = 2'b00;
    logic [2:0] intp = 3'b000;
    logic       int_en = 1'b1;
    logic       is_load = 1'b0;
    logic [1:0] src_use = 2'b00;
    logic [7:0] src_id = 8'h00;
    logic [3:0] dst_ex = 4'h0;

    logic [7:0] stage_ctr, stage_ctr_z;
    logic [1:0] jmp_type, jmp_type_z;
    logic [1:0] int_cause, int_cause_z;
    logic       int_ack, int_ack_z;
    logic [3:0] stall_cnt, stall_cnt_z;
    logic       hang, hang_z;

    int n_chk = 0;
    int n_fail = 0;
    logic [3:0] model_cnt = 4'd0;

    typedef struct {
        logic [7:0] ctr;
        logic [1:0] jt;
        logic       ack;
        logic [1:0] cause;
        logic [3:0] cnt;
        logic       hang;
        logic       chkz;
        logic [7:0] ctrz;
        string      name;
    } exp_t;

    typedef struct {
        logic       pval;
        logic [3:0] busy;
        logic [1:0] jmp;
        logic       ld;
        logic [1:0] use_;
        logic [7:0] sid;
        logic [3:0] dst;
        logic [7:0] ctr;
        logic [1:0] jt;
        logic [7:0] ctrz;
    } vec_t;

    exp_t sb[$];
    vec_t vq[$];

    pipeline_hazard_ctrl dut (
        .clk(clk), .rst(rst), .pval(pval), .busy(busy), .jmp(jmp), .intp(intp),
        .int_en(int_en), .is_load(is_load), .src_use(src_use), .src_id(src_id),
        .dst_ex(dst_ex), .stage_ctr(stage_ctr), .jmp_type(jmp_type),
        .int_cause(int_cause), .int_ack(int_ack), .stall_cnt(stall_cnt), .hang(hang)
    );

    pipeline_hazard_ctrl #(.ZERO_EXEMPT(1)) dut_z (
        .clk(clk), .rst(rst), .pval(pval), .busy(busy), .jmp(jmp), .intp(intp),
        .int_en(int_en), .is_load(is_load), .src_use(src_use), .src_id(src_id),
        .dst_ex(dst_ex), .stage_ctr(stage_ctr_z), .jmp_type(jmp_type_z),
        .int_cause(int_cause_z), .int_ack(int_ack_z), .stall_cnt(stall_cnt_z), .hang(hang_z)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic has_hold(input logic [7:0] c);
        logic h;
        h = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (c[2*k +: 2] == 2'b10) h = 1'b1;
        end
        return h;
    endfunction

    // Inputs are already driven; queue the expectation, let one falling edge pass, compare.
    task automatic step(input logic [7:0] ctr, input logic [1:0] jt, input logic ack,
                        input logic [1:0] cause, input logic chkz, input logic [7:0] ctrz,
                        input string nm);
        exp_t e;
        exp_t g;
        if (has_hold(ctr)) model_cnt = (model_cnt == 4'd15) ? 4'd15 : model_cnt + 4'd1;
        else model_cnt = 4'd0;
        e.ctr = ctr; e.jt = jt; e.ack = ack; e.cause = cause;
        e.cnt = model_cnt; e.hang = (model_cnt == 4'd15);
        e.chkz = chkz; e.ctrz = ctrz; e.name = nm;
        sb.push_back(e);
        @(negedge clk);
        #1;
        g = sb.pop_front();
        chk({g.name, "_ctr"}, 32'(stage_ctr), 32'(g.ctr));
        chk({g.name, "_jt"}, 32'(jmp_type), 32'(g.jt));
        chk({g.name, "_ack"}, 32'(int_ack), 32'(g.ack));
        chk({g.name, "_cause"}, 32'(int_cause), 32'(g.cause));
        chk({g.name, "_cnt"}, 32'(stall_cnt), 32'(g.cnt));
        chk({g.name, "_hang"}, 32'(hang), 32'(g.hang));
        if (g.chkz) chk({g.name, "_zctr"}, 32'(stage_ctr_z), 32'(g.ctrz));
    endtask

    task automatic add(input logic p, input logic [3:0] b, input logic [1:0] j, input logic l,
                       input logic [1:0] u, input logic [7:0] s, input logic [3:0] d,
                       input logic [7:0] c, input logic [1:0] t, input logic [7:0] cz);
        vec_t v;
        v.pval = p; v.busy = b; v.jmp = j; v.ld = l; v.use_ = u; v.sid = s; v.dst = d;
        v.ctr = c; v.jt = t; v.ctrz = cz;
        vq.push_back(v);
    endtask

    task automatic drive(input logic p, input logic [3:0] b, input logic [1:0] j,
                         input logic [2:0] ip, input logic ie);
        pval = p; busy = b; jmp = j; intp = ip; int_en = ie;
        is_load = 1'b0; src_use = 2'b00; src_id = 8'h00; dst_ex = 4'h0;
    endtask

    initial begin
        //   pval busy     jmp    ld    use    sid    dst    ctr    jt     ctr_z
        add(1'b1, 4'b0000, 2'b00, 1'b0, 2'b00, 8'h00, 4'h0, 8'h00, 2'd0, 8'h00);
        add(1'b1, 4'b0010, 2'b00, 1'b0, 2'b00, 8'h00, 4'h0, 8'h1A, 2'd0, 8'h1A);
        add(1'b1, 4'b1000, 2'b00, 1'b0, 2'b00, 8'h00, 4'h0, 8'hAA, 2'd0, 8'hAA);
        add(1'b1, 4'b0001, 2'b00, 1'b0, 2'b00, 8'h00, 4'h0, 8'h06, 2'd0, 8'h06);
        add(1'b1, 4'b0100, 2'b01, 1'b0, 2'b00, 8'h00, 4'h0, 8'h6A, 2'd0, 8'h6A);
        add(1'b0, 4'b0000, 2'b01, 1'b0, 2'b00, 8'h00, 4'h0, 8'h04, 2'd0, 8'h04);
        add(1'b1, 4'b0000, 2'b00, 1'b1, 2'b01, 8'h75, 4'h5, 8'h06, 2'd0, 8'h06);
        add(1'b1, 4'b0000, 2'b00, 1'b1, 2'b10, 8'h75, 4'h5, 8'h00, 2'd0, 8'h00);
        add(1'b1, 4'b0000, 2'b00, 1'b1, 2'b10, 8'h57, 4'h5, 8'h06, 2'd0, 8'h06);
        add(1'b1, 4'b0000, 2'b00, 1'b0, 2'b10, 8'h57, 4'h5, 8'h00, 2'd0, 8'h00);
        add(1'b1, 4'b0000, 2'b01, 1'b0, 2'b00, 8'h00, 4'h0, 8'h01, 2'd1, 8'h01);
        add(1'b1, 4'b0000, 2'b11, 1'b0, 2'b00, 8'h00, 4'h0, 8'h01, 2'd2, 8'h01);
        add(1'b1, 4'b0000, 2'b10, 1'b0, 2'b00, 8'h00, 4'h0, 8'h00, 2'd0, 8'h00);
        add(1'b1, 4'b0000, 2'b00, 1'b1, 2'b01, 8'h00, 4'h0, 8'h06, 2'd0, 8'h00);
        add(1'b0, 4'b0000, 2'b00, 1'b1, 2'b01, 8'h75, 4'h5, 8'h04, 2'd0, 8'h04);
        add(1'b1, 4'b0001, 2'b11, 1'b1, 2'b01, 8'h75, 4'h5, 8'h06, 2'd0, 8'h06);
        add(1'b1, 4'b0000, 2'b11, 1'b1, 2'b01, 8'h75, 4'h5, 8'h06, 2'd0, 8'h06);
        add(1'b1, 4'b0000, 2'b11, 1'b0, 2'b01, 8'h75, 4'h5, 8'h01, 2'd2, 8'h01);
        add(1'b1, 4'b0000, 2'b01, 1'b1, 2'b11, 8'h30, 4'h0, 8'h06, 2'd0, 8'h01);

        // Reset state
        #3;
        chk("rst_ctr", 32'(stage_ctr), 32'h0);
        chk("rst_jt", 32'(jmp_type), 32'h0);
        chk("rst_cnt", 32'(stall_cnt), 32'h0);
        @(negedge clk);
        @(negedge clk);
        #1;
        rst = 1'b0;

        foreach (vq[i]) begin
            drive(vq[i].pval, vq[i].busy, vq[i].jmp, 3'b000, 1'b1);
            is_load = vq[i].ld; src_use = vq[i].use_; src_id = vq[i].sid; dst_ex = vq[i].dst;
            step(vq[i].ctr, vq[i].jt, 1'b0, 2'd0, 1'b1, vq[i].ctrz, $sformatf("vec%0d", i));
        end

        // Two causes latched together while a stage is busy
        drive(1'b1, 4'b0100, 2'b00, 3'b110, 1'b1); step(8'h6A, 2'd0, 1'b0, 2'd0, 1'b0, 8'h00, "int_a");
        drive(1'b1, 4'b0100, 2'b00, 3'b000, 1'b1); step(8'hAA, 2'd0, 1'b0, 2'd1, 1'b0, 8'h00, "int_b");
        step(8'hAA, 2'd0, 1'b0, 2'd1, 1'b0, 8'h00, "int_c");
        step(8'hAA, 2'd0, 1'b0, 2'd1, 1'b0, 8'h00, "int_d");
        drive(1'b1, 4'b0000, 2'b00, 3'b000, 1'b1); step(8'h00, 2'd0, 1'b0, 2'd1, 1'b0, 8'h00, "int_e");
        step(8'h55, 2'd3, 1'b1, 2'd1, 1'b0, 8'h00, "int_ack1");
        step(8'h00, 2'd0, 1'b0, 2'd2, 1'b0, 8'h00, "int_g");
        step(8'h00, 2'd0, 1'b0, 2'd2, 1'b0, 8'h00, "int_h");
        step(8'h55, 2'd3, 1'b1, 2'd2, 1'b0, 8'h00, "int_ack2");
        drive(1'b1, 4'b0000, 2'b01, 3'b000, 1'b1); step(8'h01, 2'd1, 1'b0, 2'd2, 1'b0, 8'h00, "int_run");

        // Masked request must not be latched
        drive(1'b1, 4'b0000, 2'b00, 3'b001, 1'b0); step(8'h00, 2'd0, 1'b0, 2'd2, 1'b0, 8'h00, "mask_a");
        drive(1'b1, 4'b0000, 2'b01, 3'b000, 1'b1); step(8'h01, 2'd1, 1'b0, 2'd2, 1'b0, 8'h00, "mask_b");

        // Asynchronous reset in the middle of DRAIN
        drive(1'b1, 4'b0000, 2'b00, 3'b010, 1'b1); step(8'h00, 2'd0, 1'b0, 2'd2, 1'b0, 8'h00, "rd_a");
        drive(1'b1, 4'b0001, 2'b00, 3'b000, 1'b1); step(8'hAA, 2'd0, 1'b0, 2'd1, 1'b0, 8'h00, "rd_b");
        #2;
        rst = 1'b1;
        #1;
        chk("rd_ctr", 32'(stage_ctr), 32'h0);
        chk("rd_jt", 32'(jmp_type), 32'h0);
        chk("rd_cause", 32'(int_cause), 32'h0);
        chk("rd_ack", 32'(int_ack), 32'h0);
        chk("rd_cnt", 32'(stall_cnt), 32'h0);
        chk("rd_hang", 32'(hang), 32'h0);
        model_cnt = 4'd0;
        #2;
        rst = 1'b0;
        drive(1'b1, 4'b0000, 2'b01, 3'b000, 1'b1); step(8'h01, 2'd1, 1'b0, 2'd0, 1'b0, 8'h00, "rd_c");
        step(8'h01, 2'd1, 1'b0, 2'd0, 1'b0, 8'h00, "rd_d");

        // Watchdog saturation and release
        drive(1'b1, 4'b0001, 2'b00, 3'b000, 1'b1);
        for (int i = 0; i < 20; i++) begin
            step(8'h06, 2'd0, 1'b0, 2'd0, 1'b0, 8'h00, $sformatf("wd%0d", i));
        end
        drive(1'b1, 4'b0000, 2'b00, 3'b000, 1'b1); step(8'h00, 2'd0, 1'b0, 2'd0, 1'b0, 8'h00, "wd_rel");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
